// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and memory-bus signals of the shared bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] BUS_addr;
  logic [DATA_W-1:0] BUS_wdata;
  logic              BUS_mode;
  logic              BUS_start_transaction;
  logic [DATA_W-1:0] BUS_rdata;
  logic              BUS_rdata_valid;
  logic              BUS_write_done;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           BUS_rdata, BUS_rdata_valid, BUS_write_done,
    output if_rdata, if_done, ls_rdata, ls_done, err, busy,
           BUS_addr, BUS_wdata, BUS_mode, BUS_start_transaction
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           BUS_rdata, BUS_rdata_valid, BUS_write_done,
    input  if_rdata, if_done, ls_rdata, ls_done, err, busy,
           BUS_addr, BUS_wdata, BUS_mode, BUS_start_transaction
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin fetch/load-store arbiter and sequencer for the shared memory bus
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t            state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d, to_q, to_d, mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d, rd_val;
  logic              start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic              if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic              resp, expire, fin, both;
  // only the response matching the transaction type counts; it beats a simultaneous timeout
  assign resp   = mode_q ? bus.BUS_write_done : bus.BUS_rdata_valid;
  assign expire = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  assign fin    = state_q == S_WAIT && (resp || expire);
  assign rd_val = resp ? bus.BUS_rdata : '0;
  assign both   = bus.if_req && bus.ls_req;
  // state and registered outputs; last_grant resets to LS so fetch wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      to_q       <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      to_q       <= to_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end
  // next state: arbitrate and latch the winner in IDLE, count and capture the response in WAIT
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    to_d       = to_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = state_q == S_ISSUE ? '0 : state_q == S_WAIT ? cnt_q + CW'(1) : cnt_q;
    if_rdata_d = fin && !mode_q && !grant_q ? rd_val : if_rdata_q;
    ls_rdata_d = fin && !mode_q && grant_q ? rd_val : ls_rdata_q;
    case (state_q)
      S_IDLE: if (bus.if_req || bus.ls_req) begin
        grant_d = both ? !last_q : bus.ls_req;
        last_d  = grant_d;
        mode_d  = grant_d && bus.ls_we;
        addr_d  = grant_d ? bus.ls_addr : bus.if_addr;
        wdata_d = mode_d ? bus.ls_wdata : wdata_q;
        to_d    = 1'b0;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (fin) begin
        to_d    = !resp;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // outputs for the coming cycle, decoded from the next state
  always_comb begin
    start_d   = state_d == S_ISSUE;
    busy_d    = state_d != S_IDLE;
    if_done_d = state_d == S_DONE && !grant_d;
    ls_done_d = state_d == S_DONE && grant_d;
    err_d     = state_d == S_DONE && to_d;
  end
  assign bus.if_rdata              = if_rdata_q;
  assign bus.ls_rdata              = ls_rdata_q;
  assign bus.if_done               = if_done_q;
  assign bus.ls_done               = ls_done_q;
  assign bus.err                   = err_q;
  assign bus.busy                  = busy_q;
  assign bus.BUS_addr              = addr_q;
  assign bus.BUS_wdata             = wdata_q;
  assign bus.BUS_mode              = mode_q;
  assign bus.BUS_start_transaction = start_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  logic last_m;
  logic [31:0] if_m, ls_m, wdata_m;
  bit o_started;
  logic [31:0] o_addr, o_wdata;
  logic o_mode, o_busy_after, o_done_after;
  int o_starts, o_if_done, o_ls_done, o_err, o_err_at, o_done_at;
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  // round-robin rule: a lone requester wins, a tie goes to the port not granted last (1 = LS)
  function automatic logic win(input logic fr, input logic lr);
    return (fr && lr) ? !last_m : lr;
  endfunction
  // bus responder and monitor for one transaction; cycle c counts from the start pulse
  task automatic serve(input int lat_v, input int lat_w, input logic [31:0] rd, input bit scr);
    int n = 0;
    o_started = 0; o_starts = 0; o_if_done = 0; o_ls_done = 0; o_err = 0; o_err_at = -1; o_done_at = -1;
    @(negedge clk);
    while (!b.BUS_start_transaction && n < 20) begin @(negedge clk); n++; end
    if (!b.BUS_start_transaction) return;
    o_started = 1; o_starts = 1; o_addr = b.BUS_addr; o_mode = b.BUS_mode; o_wdata = b.BUS_wdata;
    for (int c = 1; c <= 20 && o_done_at < 0; c++) begin
      @(posedge clk); #1;
      b.BUS_rdata_valid = (c == lat_v);
      b.BUS_write_done  = (c == lat_w);
      b.BUS_rdata       = rd;
      if (scr && c == 1) begin b.if_addr = $urandom; b.ls_addr = $urandom; b.ls_wdata = $urandom; end
      @(negedge clk);
      o_starts  += int'(b.BUS_start_transaction);
      o_if_done += int'(b.if_done);
      o_ls_done += int'(b.ls_done);
      if (b.err) begin o_err++; o_err_at = c; end
      if (b.if_done || b.ls_done) o_done_at = c;
    end
    @(posedge clk); #1;
    b.BUS_rdata_valid = 1'b0; b.BUS_write_done = 1'b0;
    o_busy_after = b.busy; o_done_after = b.if_done | b.ls_done;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    b.if_req = 0; b.if_addr = 0; b.ls_req = 0; b.ls_we = 0; b.ls_addr = 0; b.ls_wdata = 0;
    b.BUS_rdata = 0; b.BUS_rdata_valid = 0; b.BUS_write_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if ({b.busy, b.BUS_start_transaction, b.if_done, b.ls_done, b.err, b.BUS_mode} !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want 000000", {b.busy, b.BUS_start_transaction, b.if_done, b.ls_done, b.err, b.BUS_mode}); end
    vectors++; if ({b.BUS_addr, b.BUS_wdata} !== 64'b0) begin miscompares++; $display("FAIL reset_bus got %h want 0", {b.BUS_addr, b.BUS_wdata}); end
    vectors++; if ({b.if_rdata, b.ls_rdata} !== 64'b0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", {b.if_rdata, b.ls_rdata}); end
    rst_n = 1'b1;
    last_m = 1'b1; if_m = 0; ls_m = 0; wdata_m = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_fetch_read;
    b.if_addr = 32'h0000_0010; b.if_req = 1'b1;
    last_m = win(1'b1, 1'b0);
    serve(2, 0, 32'h0012_8093, 0);
    b.if_req = 1'b0; if_m = 32'h0012_8093;
    vectors++; if (!o_started || o_starts !== 1) begin miscompares++; $display("FAIL fetch_start got %0d pulses want 1", o_starts); end
    vectors++; if ({o_mode, o_addr} !== {1'b0, 32'h10}) begin miscompares++; $display("FAIL fetch_bus got mode %b addr %h want 0 00000010", o_mode, o_addr); end
    vectors++; if (b.if_rdata !== if_m) begin miscompares++; $display("FAIL fetch_rdata got %h want %h", b.if_rdata, if_m); end
    vectors++; if (o_if_done !== 1 || o_ls_done !== 0 || o_err !== 0) begin miscompares++; $display("FAIL fetch_done got if %0d ls %0d err %0d want 1 0 0", o_if_done, o_ls_done, o_err); end
    vectors++; if (o_done_at !== 3) begin miscompares++; $display("FAIL fetch_latency got %0d want 3", o_done_at); end
    vectors++; if ({o_busy_after, o_done_after} !== 2'b00) begin miscompares++; $display("FAIL fetch_after got %b want 00", {o_busy_after, o_done_after}); end
  endtask
  task automatic test_ls_write;
    b.ls_addr = 32'h100; b.ls_wdata = 32'hDEAD_BEEF; b.ls_we = 1'b1; b.ls_req = 1'b1;
    last_m = win(1'b0, 1'b1);
    serve(1, 3, 32'hBAD0_BAD0, 0);
    b.ls_req = 1'b0; b.ls_we = 1'b0; wdata_m = 32'hDEAD_BEEF;
    vectors++; if ({o_mode, o_addr, o_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL write_bus got %b %h %h want 1 00000100 deadbeef", o_mode, o_addr, o_wdata); end
    vectors++; if (o_ls_done !== 1 || o_if_done !== 0 || o_err !== 0 || o_done_at !== 4) begin miscompares++; $display("FAIL write_done got ls %0d if %0d err %0d at %0d want 1 0 0 4", o_ls_done, o_if_done, o_err, o_done_at); end
    vectors++; if (b.ls_rdata !== ls_m) begin miscompares++; $display("FAIL write_rdata got %h want %h", b.ls_rdata, ls_m); end
    vectors++; if (b.BUS_wdata !== wdata_m) begin miscompares++; $display("FAIL write_hold got %h want %h", b.BUS_wdata, wdata_m); end
  endtask
  task automatic test_tie;
    logic g;
    logic [31:0] ia, la, rd;
    ia = $urandom; la = $urandom;
    b.if_addr = ia; b.ls_addr = la; b.ls_we = 1'b0; b.if_req = 1'b1; b.ls_req = 1'b1;
    g = win(1'b1, 1'b1); last_m = g;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom | 32'h1;
      serve(2, 0, rd, 0);
      if (g) ls_m = rd; else if_m = rd;
      vectors++; if (g !== logic'(i[0])) begin miscompares++; $display("FAIL tie_order txn %0d model grant %b want %b", i, g, i[0]); end
      vectors++; if (o_if_done !== int'(!g) || o_ls_done !== int'(g)) begin miscompares++; $display("FAIL tie_done txn %0d got if %0d ls %0d want grant %b", i, o_if_done, o_ls_done, g); end
      vectors++; if (o_addr !== (g ? la : ia) || {b.if_rdata, b.ls_rdata} !== {if_m, ls_m}) begin miscompares++; $display("FAIL tie_data txn %0d got %h %h %h", i, o_addr, b.if_rdata, b.ls_rdata); end
      if (i == 3) begin b.if_req = 1'b0; b.ls_req = 1'b0; end
      else begin
        if (g) b.ls_req = 1'b0; else b.if_req = 1'b0;
        ia = $urandom; la = $urandom; b.if_addr = ia; b.ls_addr = la;
        g = win(b.if_req, b.ls_req); last_m = g;
        @(posedge clk); #1;
        b.if_req = 1'b1; b.ls_req = 1'b1;
      end
    end
  endtask
  task automatic test_timeout;
    logic [31:0] rd;
    b.ls_addr = $urandom; b.ls_we = 1'b0; b.ls_req = 1'b1;
    last_m = win(1'b0, 1'b1);
    serve(0, 0, 32'hFFFF_FFFF, 0);
    b.ls_req = 1'b0; ls_m = 0;
    vectors++; if (o_err !== 1 || o_err_at !== o_done_at || o_ls_done !== 1) begin miscompares++; $display("FAIL to_err got err %0d at %0d done %0d at %0d", o_err, o_err_at, o_ls_done, o_done_at); end
    vectors++; if (o_done_at !== 5) begin miscompares++; $display("FAIL to_latency got %0d want 5", o_done_at); end
    vectors++; if (b.ls_rdata !== ls_m || o_busy_after !== 1'b0) begin miscompares++; $display("FAIL to_state got rdata %h busy %b want 0 0", b.ls_rdata, o_busy_after); end
    rd = $urandom | 32'h1;
    b.ls_addr = $urandom; b.ls_req = 1'b1;
    last_m = win(1'b0, 1'b1);
    serve(4, 0, rd, 0);
    b.ls_req = 1'b0; ls_m = rd;
    vectors++; if (o_err !== 0 || o_done_at !== 5 || b.ls_rdata !== ls_m) begin miscompares++; $display("FAIL to_edge got err %0d at %0d rdata %h want 0 5 %h", o_err, o_done_at, b.ls_rdata, ls_m); end
    b.ls_addr = $urandom; b.ls_wdata = $urandom; b.ls_we = 1'b1; b.ls_req = 1'b1;
    last_m = win(1'b0, 1'b1); wdata_m = b.ls_wdata;
    serve(2, 0, 32'h5555_5555, 0);
    b.ls_req = 1'b0; b.ls_we = 1'b0;
    vectors++; if (o_err !== 1 || o_done_at !== 5 || b.ls_rdata !== ls_m) begin miscompares++; $display("FAIL to_write got err %0d at %0d rdata %h want 1 5 %h", o_err, o_done_at, b.ls_rdata, ls_m); end
  endtask
  task automatic test_spurious;
    int bad = 0;
    logic [31:0] rd;
    b.BUS_rdata = 32'hFFFF_0000; b.BUS_rdata_valid = 1'b1; b.BUS_write_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bad += int'(b.busy | b.if_done | b.ls_done | b.BUS_start_transaction);
      @(posedge clk); #1;
    end
    b.BUS_rdata_valid = 1'b0; b.BUS_write_done = 1'b0;
    vectors++; if (bad !== 0 || b.if_rdata !== if_m) begin miscompares++; $display("FAIL idle_resp got %0d active cycles rdata %h want 0 %h", bad, b.if_rdata, if_m); end
    rd = $urandom;
    b.if_addr = $urandom; b.if_req = 1'b1;
    last_m = win(1'b1, 1'b0);
    serve(3, 1, rd, 0);
    b.if_req = 1'b0; if_m = rd;
    vectors++; if (o_done_at !== 4 || o_if_done !== 1 || o_err !== 0 || b.if_rdata !== if_m) begin miscompares++; $display("FAIL wrong_type got at %0d done %0d err %0d rdata %h want 4 1 0 %h", o_done_at, o_if_done, o_err, b.if_rdata, if_m); end
  endtask
  task automatic test_reset_mid_wait;
    int n = 0;
    int bad = 0;
    logic [31:0] ia, rd;
    b.if_addr = $urandom; b.if_req = 1'b1;
    @(negedge clk);
    while (!b.BUS_start_transaction && n < 20) begin @(negedge clk); n++; end
    vectors++; if (b.BUS_start_transaction !== 1'b1) begin miscompares++; $display("FAIL rst_start got %b want 1", b.BUS_start_transaction); end
    @(negedge clk);
    rst_n = 1'b0; #1;
    vectors++; if ({b.busy, b.if_done, b.ls_done, b.err, b.BUS_mode, b.BUS_addr, b.BUS_wdata, b.if_rdata, b.ls_rdata} !== '0) begin miscompares++; $display("FAIL rst_async got busy %b addr %h rdata %h want 0", b.busy, b.BUS_addr, b.if_rdata); end
    b.ls_req = 1'b1; b.ls_we = 1'b0;
    @(negedge clk);
    bad = int'(b.busy | b.if_done | b.ls_done);
    rst_n = 1'b1;
    last_m = 1'b1; if_m = 0; ls_m = 0; wdata_m = 0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_hold got %0d want 0", bad); end
    ia = $urandom; rd = $urandom; b.if_addr = ia; b.ls_addr = $urandom;
    last_m = win(1'b1, 1'b1);
    serve(1, 0, rd, 0);
    b.if_req = 1'b0; b.ls_req = 1'b0; if_m = rd;
    vectors++; if (o_if_done !== 1 || o_ls_done !== 0 || o_addr !== ia || b.if_rdata !== if_m) begin miscompares++; $display("FAIL rst_tie got if %0d ls %0d addr %h want 1 0 %h", o_if_done, o_ls_done, o_addr, ia); end
  endtask
  task automatic test_random;
    int r, lat, oth, eda;
    logic fr, lr, we, g, em, to;
    logic [31:0] ia, la, wd, rd, ea;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3); fr = r[0]; lr = r[1]; we = $urandom_range(0, 1);
      ia = $urandom; la = $urandom; wd = $urandom; rd = $urandom;
      lat = $urandom_range(1, 6); oth = $urandom_range(0, 6);
      b.if_req = fr; b.ls_req = lr; b.ls_we = we; b.if_addr = ia; b.ls_addr = la; b.ls_wdata = wd;
      g = win(fr, lr); last_m = g;
      em = g && we; ea = g ? la : ia;
      if (em) wdata_m = wd;
      to = lat > 4; eda = to ? 5 : lat + 1;
      serve(em ? oth : lat, em ? lat : oth, rd, 1);
      b.if_req = 1'b0; b.ls_req = 1'b0;
      if (!em && g) ls_m = to ? 32'h0 : rd;
      if (!em && !g) if_m = to ? 32'h0 : rd;
      vectors++; if (!o_started || o_starts !== 1 || {o_mode, o_addr, o_wdata} !== {em, ea, wdata_m}) begin miscompares++; $display("FAIL rnd_bus %0d got %b %h %h want %b %h %h", i, o_mode, o_addr, o_wdata, em, ea, wdata_m); end
      vectors++; if (o_if_done !== int'(!g) || o_ls_done !== int'(g) || o_done_at !== eda) begin miscompares++; $display("FAIL rnd_done %0d got if %0d ls %0d at %0d want grant %b at %0d", i, o_if_done, o_ls_done, o_done_at, g, eda); end
      vectors++; if (o_err !== int'(to) || {b.if_rdata, b.ls_rdata} !== {if_m, ls_m}) begin miscompares++; $display("FAIL rnd_data %0d got err %0d %h %h want %b %h %h", i, o_err, b.if_rdata, b.ls_rdata, to, if_m, ls_m); end
    end
  endtask
  initial begin
    test_reset;
    test_fetch_read;
    test_ls_write;
    test_tie;
    test_timeout;
    test_spurious;
    test_reset_mid_wait;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
